game_sequencer: RTL



---
 rtl/game_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer
// ---------------------------------------------------------------------------
// Round controller for the balance game. Turns the start button into a
// one-cycle start strobe for the level register, runs a countdown, then a
// timed play phase that judges lever equilibrium against a per-level
// tolerance, and reports win/lose plus remaining ticks to the display.
//
// Ports
//   clock         in   system clock
//   reset_n       in   asynchronous active-low reset
//   start_btn     in   debounced, synchronous start button (level)
//   alavanca1     in   signed lever 1 position (16 bit)
//   alavanca2     in   signed lever 2 position (16 bit)
//   nivel         in   latched level from the level register (2 bit)
//   nivel_locked  in   level register has latched a level
//   start_game    out  one-cycle strobe to the level register
//   level_clear   out  one-cycle strobe that resets the level register
//   state         out  FSM state code (IDLE=0 SELECT=1 COUNTDOWN=2
//                      PLAY=3 WIN=4 LOSE=5)
//   seconds_left  out  remaining ticks in COUNTDOWN/PLAY, held in WIN/LOSE
//   in_band       out  combinational equilibrium flag, 0 outside PLAY
//   win           out  high while in WIN
//   lose          out  high while in LOSE
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int unsigned TICK_DIV         = 50000000,
  parameter int unsigned COUNTDOWN_TICKS  = 3,
  parameter int unsigned TIME_LIMIT_TICKS = 30,
  parameter int unsigned HOLD_TICKS       = 5,
  parameter int unsigned TOL0             = 4096,
  parameter int unsigned TOL1             = 2048,
  parameter int unsigned TOL2             = 1024,
  parameter int unsigned TOL3             = 512
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [15:0] alavanca1,
  input  logic [15:0] alavanca2,
  input  logic [1:0]  nivel,
  input  logic        nivel_locked,
  output logic        start_game,
  output logic        level_clear,
  output logic [2:0]  state,
  output logic [7:0]  seconds_left,
  output logic        in_band,
  output logic        win,
  output logic        lose
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
    S_WIN       = 3'd4,
    S_LOSE      = 3'd5
  } state_e;

  state_e             state_q;
  logic               start_q;
  logic               start_game_q;
  logic               level_clear_q;
  logic               win_q;
  logic               lose_q;
  logic [7:0]         seconds_q;
  logic [7:0]         hold_q;
  logic [DIV_W-1:0]   div_q;

  logic               start_rise;
  logic               tick;
  logic [16:0]        diff;
  logic [16:0]        mag;
  logic [16:0]        tol_sel;
  logic               band_raw;

  assign start_rise = start_btn & ~start_q;

  // The divider only advances in COUNTDOWN and PLAY, so outside those
  // states it sits at whatever it was cleared to on entry.
  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  // 17-bit sign-extended difference cannot overflow; the magnitude of the
  // most negative value (-65535) still fits in 17 unsigned bits.
  assign diff = {alavanca1[15], alavanca1} - {alavanca2[15], alavanca2};
  assign mag  = diff[16] ? (~diff + 17'd1) : diff;

  always_comb begin
    tol_sel = 17'(TOL0);
    case (nivel)
      2'd0:    tol_sel = 17'(TOL0);
      2'd1:    tol_sel = 17'(TOL1);
      2'd2:    tol_sel = 17'(TOL2);
      default: tol_sel = 17'(TOL3);
    endcase
  end

  assign band_raw = (mag <= tol_sel);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      start_game_q  <= 1'b0;
      level_clear_q <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      seconds_q     <= 8'd0;
      hold_q        <= 8'd0;
      div_q         <= '0;
    end else begin
      start_q       <= start_btn;
      start_game_q  <= 1'b0;
      level_clear_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q      <= S_SELECT;
            start_game_q <= 1'b1;
            seconds_q    <= 8'(COUNTDOWN_TICKS);
            div_q        <= '0;
          end
        end
        S_SELECT: begin
          if (nivel_locked) begin
            state_q <= S_COUNTDOWN;
            div_q   <= '0;
          end
        end
        S_COUNTDOWN: begin
          div_q <= tick ? '0 : div_q + 1'b1;
          if (tick) begin
            if (seconds_q == 8'd1) begin
              state_q   <= S_PLAY;
              seconds_q <= 8'(TIME_LIMIT_TICKS);
              hold_q    <= 8'd0;
            end else begin
              seconds_q <= seconds_q - 8'd1;
            end
          end
        end
        S_PLAY: begin
          div_q <= tick ? '0 : div_q + 1'b1;
          // Any out-of-band cycle breaks the streak, not just on ticks.
          if (!band_raw) begin
            hold_q <= 8'd0;
          end else if (tick) begin
            hold_q <= hold_q + 8'd1;
          end
          if (tick) begin
            // Completing the hold wins even on the final tick of the round.
            if (band_raw && (hold_q + 8'd1 == 8'(HOLD_TICKS))) begin
              state_q <= S_WIN;
              win_q   <= 1'b1;
            end else if (seconds_q == 8'd1) begin
              state_q   <= S_LOSE;
              lose_q    <= 1'b1;
              seconds_q <= 8'd0;
            end else begin
              seconds_q <= seconds_q - 8'd1;
            end
          end
        end
        S_WIN, S_LOSE: begin
          if (start_rise) begin
            state_q       <= S_IDLE;
            level_clear_q <= 1'b1;
            seconds_q     <= 8'd0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
            hold_q        <= 8'd0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state        = state_q;
  assign start_game   = start_game_q;
  assign level_clear  = level_clear_q;
  assign seconds_left = seconds_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign in_band      = (state_q == S_PLAY) & band_raw;

endmodule
